// File: rtl/global_stall_pkg.sv
// Shared defaults and types for the global-stall multi-lane pipeline.
package global_stall_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_DEPTH   = 4;
  localparam int unsigned DEF_LANES   = 2;
  localparam int unsigned STALL_CNT_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } lane_stage_t;

endpackage

// File: rtl/global_stall_pipe_stage.sv
// One pipeline register stage: holds when en is low, adds 1 to valid data on advance.
module stall_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Data register keeps its old value under a bubble so it never goes X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data + WIDTH'(1);
    end
  end

endmodule

// File: rtl/global_stall_pipe.sv
// LANES x DEPTH pipeline frozen by a single global stall; stall counter
// is built only when STALL_CNT_EN is defined (otherwise stall_count reads 0).
module global_stall_pipe
  import global_stall_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned LANES = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic [LANES-1:0]       out_ready,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic             stall;
  logic             advance;
  logic             stg_valid [LANES][DEPTH];
  logic [WIDTH-1:0] stg_data  [LANES][DEPTH];

  // Only a lane actually presenting data can block; idle lanes ignore ready.
  always_comb begin
    stall    = |(out_valid & ~out_ready);
    advance  = ~stall;
    in_ready = advance;
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      logic             v_in;
      logic [WIDTH-1:0] d_in;

      if (s == 0) begin : g_head
        assign v_in = in_valid[l];
        assign d_in = in_data[l*WIDTH +: WIDTH];
      end else begin : g_body
        assign v_in = stg_valid[l][s-1];
        assign d_in = stg_data[l][s-1];
      end

      stall_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en       (advance),
        .in_valid (v_in),
        .in_data  (d_in),
        .out_valid(stg_valid[l][s]),
        .out_data (stg_data[l][s])
      );
    end

    assign out_valid[l]                = stg_valid[l][DEPTH-1];
    assign out_data[l*WIDTH +: WIDTH]  = stg_data[l][DEPTH-1];
  end

`ifdef STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_global_stall_pipe.sv
// Self-checking bench for global_stall_pipe (LANES=2, DEPTH=4, WIDTH=32).
module tb_global_stall_pipe;

  localparam int W  = 32;
  localparam int DP = 4;
  localparam int LN = 2;
`ifdef STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [LN-1:0]   in_valid = '0;
  logic [LN*W-1:0] in_data = '0;
  logic            in_ready;
  logic [LN-1:0]   out_valid;
  logic [LN*W-1:0] out_data;
  logic [LN-1:0]   out_ready = '0;
  logic [31:0]     stall_count;

  int checks = 0;
  int fails  = 0;
  logic [W-1:0] sbq [LN][$];

  global_stall_pipe #(.WIDTH(W), .DEPTH(DP), .LANES(LN)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = {d1, d0};
    out_ready = r;
    #1;
  endtask

  // Scoreboard: push expected on acceptance, pop on transfer.
  always @(negedge clk) begin
    if (reset) begin
      for (int l = 0; l < LN; l++) sbq[l].delete();
    end else begin
      for (int l = 0; l < LN; l++) begin
        if (out_valid[l] && out_ready[l] && in_ready) begin
          if (sbq[l].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL sb_dup lane%0d: got %0h expected no transfer", l, out_data[l*W +: W]);
          end else begin
            check($sformatf("sb_lane%0d", l), 64'(out_data[l*W +: W]), 64'(sbq[l].pop_front()));
          end
        end
        if (in_ready && in_valid[l]) sbq[l].push_back(in_data[l*W +: W] + W'(DP));
      end
    end
  end

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  initial begin
    vec_t tbl [3];
    int adv;
    bit exp_rdy;
    logic [1:0] r;

    tbl[0] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002, 32'h0000_0004};
    tbl[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0003};
    tbl[2] = '{32'h0000_0007, 32'h7FFF_FFFF, 32'h0000_000B, 32'h8000_0003};

    // Asynchronous reset, checked before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    check("rst_stall_count", 64'(stall_count), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming on both lanes
    for (int i = 0; i < 12; i++) begin
      apply(2'b11, 32'(i), 32'(100 + i), 2'b11);
      check("stream_in_ready", 64'(in_ready), 64'h1);
      if (i >= DP) begin
        check("stream_valid", 64'(out_valid), 64'h3);
        check("stream_d0", 64'(out_data[31:0]), 64'(i));
        check("stream_d1", 64'(out_data[63:32]), 64'(100 + i));
      end else begin
        check("stream_fill_valid", 64'(out_valid), 64'h0);
      end
    end
    repeat (5) apply(2'b00, 0, 0, 2'b11);
    check("drain_valid", 64'(out_valid), 64'h0);

    // Global stall from lane 1 for three cycles; source holds while not ready
    adv = 0;
    for (int c = 0; c < 16; c++) begin
      r = (c >= 6 && c <= 8) ? 2'b01 : 2'b11;
      exp_rdy = !(c >= 6 && c <= 8);
      apply(2'b11, 32'(200 + adv), 32'(300 + adv), r);
      check("gs_in_ready", 64'(in_ready), 64'(exp_rdy));
      if (adv >= DP) begin
        check("gs_valid", 64'(out_valid), 64'h3);
        check("gs_d0", 64'(out_data[31:0]), 64'(200 + adv));
        check("gs_d1", 64'(out_data[63:32]), 64'(300 + adv));
      end
      if (exp_rdy) adv++;
    end
    check("gs_stall_count", 64'(stall_count), CNT_EN ? 64'd3 : 64'd0);
    repeat (5) apply(2'b00, 0, 0, 2'b11);

    // Empty lane 1 with ready low must not stall lane 0
    for (int i = 0; i < 8; i++) begin
      apply(2'b01, 32'(400 + i), 0, 2'b01);
      check("idle_in_ready", 64'(in_ready), 64'h1);
      check("idle_v1", 64'(out_valid[1]), 64'h0);
      if (i >= DP) begin
        check("idle_v0", 64'(out_valid[0]), 64'h1);
        check("idle_d0", 64'(out_data[31:0]), 64'(400 + i));
      end
    end
    check("idle_stall_count", 64'(stall_count), CNT_EN ? 64'd3 : 64'd0);
    repeat (5) apply(2'b00, 0, 0, 2'b11);

    // Table: transform and wrap-around
    for (int t = 0; t < 3; t++) begin
      apply(2'b11, tbl[t].d0, tbl[t].d1, 2'b11);
      repeat (DP) apply(2'b00, 0, 0, 2'b11);
      check("tbl_valid", 64'(out_valid), 64'h3);
      check("tbl_d0", 64'(out_data[31:0]), 64'(tbl[t].e0));
      check("tbl_d1", 64'(out_data[63:32]), 64'(tbl[t].e1));
    end
    repeat (2) apply(2'b00, 0, 0, 2'b11);

    // Bubble pattern 1,0,1 on lane 0
    apply(2'b01, 32'd10, 0, 2'b11);
    apply(2'b00, 32'd11, 0, 2'b11);
    apply(2'b01, 32'd12, 0, 2'b11);
    apply(2'b00, 0, 0, 2'b11);
    apply(2'b00, 0, 0, 2'b11);
    check("bub_v0_a", 64'(out_valid[0]), 64'h1);
    check("bub_d0_a", 64'(out_data[31:0]), 64'd14);
    apply(2'b00, 0, 0, 2'b11);
    check("bub_v0_b", 64'(out_valid[0]), 64'h0);
    apply(2'b00, 0, 0, 2'b11);
    check("bub_v0_c", 64'(out_valid[0]), 64'h1);
    check("bub_d0_c", 64'(out_data[31:0]), 64'd16);
    repeat (4) apply(2'b00, 0, 0, 2'b11);

    // Fill, stall on both lanes, then reset in the middle of the stall
    for (int i = 0; i < 6; i++) apply(2'b11, 32'(500 + i), 32'(600 + i), 2'b11);
    apply(2'b11, 32'd506, 32'd606, 2'b00);
    check("ms_in_ready", 64'(in_ready), 64'h0);
    apply(2'b11, 32'd506, 32'd606, 2'b00);
    apply(2'b11, 32'd506, 32'd606, 2'b00);
    check("ms_stall_count", 64'(stall_count), CNT_EN ? 64'd5 : 64'd0);
    #1 reset = 1'b1;
    #1;
    check("ms_rst_valid", 64'(out_valid), 64'h0);
    check("ms_rst_data", 64'(out_data), 64'h0);
    check("ms_rst_in_ready", 64'(in_ready), 64'h1);
    check("ms_rst_count", 64'(stall_count), 64'h0);
    apply(2'b00, 0, 0, 2'b11);
    reset = 1'b0;
    apply(2'b01, 32'd50, 0, 2'b11);
    for (int i = 1; i < DP; i++) begin
      apply(2'b00, 0, 0, 2'b11);
      check("post_rst_empty", 64'(out_valid), 64'h0);
    end
    apply(2'b00, 0, 0, 2'b11);
    check("post_rst_valid", 64'(out_valid), 64'h1);
    check("post_rst_d0", 64'(out_data[31:0]), 64'd54);

    repeat (6) apply(2'b00, 0, 0, 2'b11);
    check("sb_empty_lane0", 64'(sbq[0].size()), 64'h0);
    check("sb_empty_lane1", 64'(sbq[1].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/global_stall_pipe.md
# global_stall_pipe

Parametrised multi-lane pipeline with a single global stall. Generalises the fixed two-lane, fixed-depth global-stall pipeline to LANES independent data lanes of DEPTH stages and WIDTH bits, with a valid/ready handshake at both ends. Any blocked output freezes every stage of every lane in the same cycle. Sits between the per-lane data sources and the output consumers in the global-stall top level.

## Interface
- WIDTH, 32, data width per lane
- DEPTH, 4, pipeline stages per lane (≥1)
- LANES, 2, number of lanes (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  LANES  per-lane input valid
- in_data  input  LANES*WIDTH  per-lane input data, lane i at [i*WIDTH +: WIDTH]
- in_ready  output  1  global: high when the pipeline advances this cycle
- out_valid  output  LANES  per-lane output valid (last-stage valid)
- out_data  output  LANES*WIDTH  per-lane output data (last-stage data)
- out_ready  input  LANES  per-lane consumer ready
- stall_count  output  32  number of stalled cycles since reset

## Operation
- Per-lane state: DEPTH stages, each holding a valid bit and a WIDTH data register.
- stall = OR over lanes of (out_valid[i] & ~out_ready[i]). A lane with out_valid=0 never stalls, whatever its out_ready.
- in_ready = ~stall, combinational from last-stage valids and out_ready.
- No stall: every stage of every lane shifts by one. Stage 0 loads in_valid[i], and in_data[i]+1 when in_valid[i]=1. Stage k loads stage k-1 valid, and data+1 when that valid=1. Bubbles (valid=0) shift like data and are not collapsed.
- Stall: every stage of every lane holds valid and data. in_data is not captured.
- Transfer at output lane i: out_valid[i] & out_ready[i] & ~stall. During a stall no lane transfers, even one whose own ready is high.
- Data transform: out_data = in_data + DEPTH, modulo 2^WIDTH (wraps, no saturation).
- Invalid stages keep their previous data register value. Data is don't-care when valid=0, but is never X after reset.
- stall_count increments by 1 in each cycle with stall=1. It saturates at 0xFFFFFFFF.

## Timing
- Reset (asynchronous assert): all valid bits 0, all data registers 0, stall_count 0. Outputs then read out_valid=0, out_data=0, in_ready=1.
- Release: the first capture is on the first rising edge with reset low.
- Latency: DEPTH cycles from input acceptance to out_valid, with no stall. Throughput is one beat per lane per cycle.
- Stall response: zero cycles. in_ready drops in the same cycle that out_ready falls against a valid output.
- Recovery: the pipeline advances on the first edge where stall=0. Nothing is lost or duplicated.
- Simultaneous stall on several lanes: same behaviour as a single stall. stall_count increments by one only.
- Reset mid-stall: all in-flight data is discarded and stall_count clears. in_ready=1 after reset.

## Configuration
- STALL_CNT_EN defined: stall_count is implemented as above.
- STALL_CNT_EN undefined: no counter register is built and stall_count is tied to 0. The port still exists.

## Structure
- Package global_stall_pkg holds:
  - default WIDTH/DEPTH/LANES localparams
  - STALL_CNT_W = 32
  - a lane_stage_t typedef (valid + data).
- Sub-module stall_stage: one register stage with enable (~stall) and +1 on valid data. It is instantiated DEPTH×LANES times via generate.
- Top level contains the stall reduction, in_ready, the counter and port packing.

## Test plan
- Reset: assert reset mid-clock → out_valid=0, out_data=0, in_ready=1, stall_count=0 immediately, without waiting for a clock edge.
- Streaming: LANES=2, DEPTH=4, all out_ready=1. Lane0 gets 0,1,2,… and lane1 gets 100,101,… → out_data 4,5,6 and 104,105,… from cycle 4. No gaps; in_ready stays 1.
- Global stall: drop out_ready[1] for 3 cycles while out_valid[1]=1 → both lanes hold their out_data, in_ready=0, stall_count=3, and no lane0 transfer occurs. Resume gives an exact sequence with no loss or duplicates.
- Idle-lane ready: lane1 empty and out_ready[1]=0 → no stall, and lane0 streams normally.
- Wrap: in_data 0xFFFFFFFE, DEPTH=4 → out_data 0x00000002.
- Bubbles plus reset mid-stall:
  - pattern valid 1,0,1 → output valid 1,0,1 spaced identically;
  - then reset during a stall → all valids clear, stall_count=0, and the next accepted item appears after DEPTH cycles.
